counter_seq_ctrl: RTL and testbench

- Wishbone-slave sequencer for the 16-bit user-area counter.
- Holds the counter's configuration: prescaler, reload value, compare value, mode and output enable.
- Runs a start/stop/reload state machine that drives the counter's enable, load and load-value inputs and watches its count output.
- Raises a compare-match interrupt and drives the pad output-enables for the counter's IO pins.

---
 rtl/counter_seq_pkg.sv | 34 +++
 rtl/counter_seq_regs.sv | 148 ++++++++++++++
 rtl/counter_seq_ctrl.sv | 119 +++++++++++
 tb/tb_counter_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_seq_pkg : shared types and register map for the counter sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package counter_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Word offsets, i.e. wbs_adr_i[7:2]
   localparam logic [5:0] C_OFF_CTRL     = 6'h00;
   localparam logic [5:0] C_OFF_PRESCALE = 6'h01;
   localparam logic [5:0] C_OFF_LOAD     = 6'h02;
   localparam logic [5:0] C_OFF_CMP      = 6'h03;
   localparam logic [5:0] C_OFF_STATUS   = 6'h04;
   localparam logic [5:0] C_OFF_COUNT    = 6'h05;

   localparam int C_CTRL_START  = 0;
   localparam int C_CTRL_STOP   = 1;
   localparam int C_CTRL_MODE   = 2;
   localparam int C_CTRL_IRQ_EN = 3;
   localparam int C_CTRL_OE     = 4;

   localparam int C_STAT_MATCH  = 0;
   localparam int C_STAT_BUSY   = 1;
   localparam int C_STAT_STATE  = 8;

endpackage
`default_nettype wire

// File: rtl/counter_seq_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_seq_regs : Wishbone decode, configuration registers and read mux
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_seq_regs
   import counter_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic [31:0]      wbs_dat_o,
   output logic             wbs_ack_o,
   input  logic [CNT_W-1:0] cnt_value_i,
   input  state_e           state_i,
   input  logic             match_set_i,
   output logic             start_o,
   output logic             stop_o,
   output logic             mode_o,
   output logic             irq_en_o,
   output logic             oe_o,
   output logic [CNT_W-1:0] prescale_o,
   output logic [CNT_W-1:0] load_o,
   output logic [CNT_W-1:0] cmp_o,
   output logic             match_o
);

   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             mode_q, mode_d, irq_en_q, irq_en_d, oe_q, oe_d, match_q, match_d;
   logic [CNT_W-1:0] ps_q, ps_d, ld_q, ld_d, cmp_q, cmp_d;
   logic             w_hit, w_wr, w_clr, w_unused;
   logic [5:0]       w_off;
   logic [CNT_W-1:0] w_mask;
   logic [31:0]      w_rdata;

   function automatic logic [CNT_W-1:0] f_merge(input logic [CNT_W-1:0] old_v,
                                                 input logic [CNT_W-1:0] new_v,
                                                 input logic [CNT_W-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   // The ~ack_q term keeps a held strobe from re-triggering during its own ack
   assign w_hit  = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign w_wr   = w_hit & wbs_we_i;
   assign w_off  = wbs_adr_i[7:2];
   assign w_mask = CNT_W'({{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}});
   assign w_clr  = w_wr & (w_off == C_OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[C_STAT_MATCH];

   assign start_o = w_wr & (w_off == C_OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[C_CTRL_START];
   assign stop_o  = w_wr & (w_off == C_OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[C_CTRL_STOP];

   assign w_unused = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:CNT_W]};

   always_comb begin
      w_rdata = '0;
      case (w_off)
         C_OFF_CTRL: begin
            w_rdata[C_CTRL_MODE]   = mode_q;
            w_rdata[C_CTRL_IRQ_EN] = irq_en_q;
            w_rdata[C_CTRL_OE]     = oe_q;
         end
         C_OFF_PRESCALE: w_rdata[CNT_W-1:0] = ps_q;
         C_OFF_LOAD:     w_rdata[CNT_W-1:0] = ld_q;
         C_OFF_CMP:      w_rdata[CNT_W-1:0] = cmp_q;
         C_OFF_STATUS: begin
            w_rdata[C_STAT_MATCH] = match_q;
            w_rdata[C_STAT_BUSY]  = (state_i == ST_LOAD) | (state_i == ST_RUN);
            w_rdata[C_STAT_STATE+1:C_STAT_STATE] = state_i;
         end
         C_OFF_COUNT:    w_rdata[CNT_W-1:0] = cnt_value_i;
         default:        w_rdata = '0;
      endcase
   end

   always_comb begin
      mode_d   = mode_q;
      irq_en_d = irq_en_q;
      oe_d     = oe_q;
      ps_d     = ps_q;
      ld_d     = ld_q;
      cmp_d    = cmp_q;
      // A new match in the clearing cycle takes priority
      match_d  = match_set_i | (match_q & ~w_clr);
      ack_d    = w_hit;
      dat_d    = '0;
      if (w_wr) begin
         case (w_off)
            C_OFF_CTRL: begin
               if (wbs_sel_i[0]) begin
                  mode_d   = wbs_dat_i[C_CTRL_MODE];
                  irq_en_d = wbs_dat_i[C_CTRL_IRQ_EN];
                  oe_d     = wbs_dat_i[C_CTRL_OE];
               end
            end
            C_OFF_PRESCALE: ps_d  = f_merge(ps_q, wbs_dat_i[CNT_W-1:0], w_mask);
            C_OFF_LOAD:     ld_d  = f_merge(ld_q, wbs_dat_i[CNT_W-1:0], w_mask);
            C_OFF_CMP:      cmp_d = f_merge(cmp_q, wbs_dat_i[CNT_W-1:0], w_mask);
            default: ;
         endcase
      end
      if (w_hit & ~wbs_we_i) dat_d = w_rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         mode_q   <= 1'b0;
         irq_en_q <= 1'b0;
         oe_q     <= 1'b0;
         match_q  <= 1'b0;
         ps_q     <= '0;
         ld_q     <= '0;
         cmp_q    <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         mode_q   <= mode_d;
         irq_en_q <= irq_en_d;
         oe_q     <= oe_d;
         match_q  <= match_d;
         ps_q     <= ps_d;
         ld_q     <= ld_d;
         cmp_q    <= cmp_d;
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign mode_o     = mode_q;
   assign irq_en_o   = irq_en_q;
   assign oe_o       = oe_q;
   assign prescale_o = ps_q;
   assign load_o     = ld_q;
   assign cmp_o      = cmp_q;
   assign match_o    = match_q;

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_seq_ctrl : start/stop/reload sequencer driving the user-area counter
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_seq_ctrl
   import counter_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic [31:0]      wbs_dat_o,
   output logic             wbs_ack_o,
   input  logic [CNT_W-1:0] cnt_value_i,
   output logic             cnt_en_o,
   output logic             cnt_load_o,
   output logic [CNT_W-1:0] cnt_load_val_o,
   output logic             irq_o,
   output logic [CNT_W-1:0] io_oeb_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic             w_start, w_stop, w_mode, w_irq_en, w_oe, w_match, w_match_set, w_cmp_hit;
   logic [CNT_W-1:0] w_prescale, w_load, w_cmp;

   counter_seq_regs #(
      .BASE_ADDR (BASE_ADDR),
      .CNT_W     (CNT_W)
   ) u_regs (
      .clk         (clk),
      .reset       (reset),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_dat_o   (wbs_dat_o),
      .wbs_ack_o   (wbs_ack_o),
      .cnt_value_i (cnt_value_i),
      .state_i     (state_q),
      .match_set_i (w_match_set),
      .start_o     (w_start),
      .stop_o      (w_stop),
      .mode_o      (w_mode),
      .irq_en_o    (w_irq_en),
      .oe_o        (w_oe),
      .prescale_o  (w_prescale),
      .load_o      (w_load),
      .cmp_o       (w_cmp),
      .match_o     (w_match)
   );

   assign w_cmp_hit = (cnt_value_i == w_cmp);

   always_comb begin
      state_d        = state_q;
      presc_d        = presc_q;
      cnt_en_o       = 1'b0;
      cnt_load_o     = 1'b0;
      cnt_load_val_o = '0;
      w_match_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_start & ~w_stop) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_load_o     = 1'b1;
            cnt_load_val_o = w_load;
            presc_d        = '0;
            if (w_stop)       state_d = ST_IDLE;
            else if (w_start) state_d = ST_LOAD;
            else              state_d = ST_RUN;
         end
         ST_RUN: begin
            // >= so a PRESCALE lowered mid-run wraps at once instead of overflowing
            if (w_cmp_hit) begin
               w_match_set = 1'b1;
            end else if (presc_q >= w_prescale) begin
               cnt_en_o = 1'b1;
               presc_d  = '0;
            end else begin
               presc_d  = presc_q + CNT_W'(1);
            end
            if (w_stop)         state_d = ST_IDLE;
            else if (w_start)   state_d = ST_LOAD;
            else if (w_cmp_hit) state_d = w_mode ? ST_LOAD : ST_DONE;
         end
         ST_DONE: begin
            if (w_stop)       state_d = ST_IDLE;
            else if (w_start) state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
      end
   end

   assign irq_o    = w_match & w_irq_en;
   assign io_oeb_o = {CNT_W{~w_oe}};

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_seq_ctrl : randomized bench with a cycle reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_seq_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr, wbs_dat_w;
   logic [31:0] wbs_dat_r;
   logic        wbs_ack;
   logic [15:0] cnt;
   logic        cnt_en, cnt_load, irq;
   logic [15:0] cnt_load_val, io_oeb;

   int n_vec = 0;
   int n_err = 0;
   int n_en  = 0;

   // Reference model: sequencer phase, cycles spent in the current run, register image
   int          m_state;
   int          m_run;
   logic [15:0] m_ps, m_ld, m_cmp;
   bit          m_mode, m_irqen, m_oe, m_match, m_ack;
   logic [31:0] m_dat;

   counter_seq_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .wbs_cyc_i      (wbs_cyc),
      .wbs_stb_i      (wbs_stb),
      .wbs_we_i       (wbs_we),
      .wbs_sel_i      (wbs_sel),
      .wbs_adr_i      (wbs_adr),
      .wbs_dat_i      (wbs_dat_w),
      .wbs_dat_o      (wbs_dat_r),
      .wbs_ack_o      (wbs_ack),
      .cnt_value_i    (cnt),
      .cnt_en_o       (cnt_en),
      .cnt_load_o     (cnt_load),
      .cnt_load_val_o (cnt_load_val),
      .irq_o          (irq),
      .io_oeb_o       (io_oeb)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_run = 0;
      m_ps = 16'h0; m_ld = 16'h0; m_cmp = 16'h0;
      m_mode = 0; m_irqen = 0; m_oe = 0; m_match = 0; m_ack = 0;
      m_dat = 32'h0;
   endtask

   function automatic logic [31:0] model_read(input logic [5:0] off);
      logic [31:0] r;
      logic [1:0]  code;
      r = 32'h0;
      code = 2'(m_state);
      case (off)
         6'd0: r = {27'h0, m_oe, m_irqen, m_mode, 2'b00};
         6'd1: r = {16'h0, m_ps};
         6'd2: r = {16'h0, m_ld};
         6'd3: r = {16'h0, m_cmp};
         6'd4: r = {22'h0, code, 6'h0, (m_state == 1 || m_state == 2), m_match};
         6'd5: r = {16'h0, cnt};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // One clock cycle: entered at the negedge with inputs stable, returns at the next negedge
   task automatic cycle();
      bit          match_now, en_exp, hit, wr, start, stop, clr;
      int          ns, run_n;
      logic [5:0]  off;
      logic [15:0] nc, ps_n, ld_n, cmp_n;
      bit          mode_n, irq_n, oe_n, match_n;
      logic [31:0] dat_n;
      #1;
      match_now = (m_state == 2) && (cnt == m_cmp);
      en_exp    = (m_state == 2) && !match_now && ((m_run % (int'(m_ps) + 1)) == int'(m_ps));
      check_val("cnt_en",   32'(cnt_en),   32'(en_exp));
      check_val("cnt_load", 32'(cnt_load), 32'(m_state == 1));
      check_val("load_val", 32'(cnt_load_val), (m_state == 1) ? 32'(m_ld) : 32'h0);
      check_val("irq",      32'(irq),      32'(m_match && m_irqen));
      check_val("io_oeb",   32'(io_oeb),   m_oe ? 32'h0 : 32'hFFFF);
      check_val("ack",      32'(wbs_ack),  32'(m_ack));
      check_val("rdata",    wbs_dat_r,     m_dat);
      if (cnt_en) n_en++;

      off   = wbs_adr[7:2];
      hit   = wbs_cyc && wbs_stb && (wbs_adr[31:8] == BASE[31:8]) && !m_ack;
      wr    = hit && wbs_we;
      start = wr && off == 6'd0 && wbs_sel[0] && wbs_dat_w[0];
      stop  = wr && off == 6'd0 && wbs_sel[0] && wbs_dat_w[1];
      clr   = wr && off == 6'd4 && wbs_sel[0] && wbs_dat_w[0];

      ns = m_state;
      if (stop)                        ns = 0;
      else if (start)                  ns = 1;
      else if (m_state == 1)           ns = 2;
      else if (match_now)              ns = m_mode ? 1 : 3;
      run_n = (m_state == 2 && ns == 2) ? m_run + 1 : 0;

      ps_n = m_ps; ld_n = m_ld; cmp_n = m_cmp;
      mode_n = m_mode; irq_n = m_irqen; oe_n = m_oe;
      if (wr) begin
         if (off == 6'd0 && wbs_sel[0]) begin
            mode_n = wbs_dat_w[2]; irq_n = wbs_dat_w[3]; oe_n = wbs_dat_w[4];
         end
         if (off == 6'd1) begin
            if (wbs_sel[0]) ps_n[7:0]  = wbs_dat_w[7:0];
            if (wbs_sel[1]) ps_n[15:8] = wbs_dat_w[15:8];
         end
         if (off == 6'd2) begin
            if (wbs_sel[0]) ld_n[7:0]  = wbs_dat_w[7:0];
            if (wbs_sel[1]) ld_n[15:8] = wbs_dat_w[15:8];
         end
         if (off == 6'd3) begin
            if (wbs_sel[0]) cmp_n[7:0]  = wbs_dat_w[7:0];
            if (wbs_sel[1]) cmp_n[15:8] = wbs_dat_w[15:8];
         end
      end
      match_n = match_now || (m_match && !clr);
      dat_n   = (hit && !wbs_we) ? model_read(off) : 32'h0;
      nc      = cnt_load ? cnt_load_val : (cnt_en ? cnt + 16'd1 : cnt);

      @(posedge clk);
      #1;
      cnt = nc;
      m_state = ns; m_run = run_n;
      m_ps = ps_n; m_ld = ld_n; m_cmp = cmp_n;
      m_mode = mode_n; m_irqen = irq_n; m_oe = oe_n; m_match = match_n;
      m_ack = hit; m_dat = dat_n;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic bus_idle();
      wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 4'h0;
      wbs_adr = 32'h0; wbs_dat_w = 32'h0;
   endtask

   task automatic wb_write(input logic [7:0] offs, input logic [31:0] d, input logic [3:0] s);
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = s;
      wbs_adr = BASE | {24'h0, offs}; wbs_dat_w = d;
      cycle();
      cycle();
      bus_idle();
   endtask

   task automatic wb_read(input logic [7:0] offs, output logic [31:0] d);
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF;
      wbs_adr = BASE | {24'h0, offs}; wbs_dat_w = 32'h0;
      cycle();
      d = wbs_dat_r;
      cycle();
      bus_idle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_en"},   32'(cnt_en),       32'h0);
      check_val({tag, "_load"}, 32'(cnt_load),     32'h0);
      check_val({tag, "_lval"}, 32'(cnt_load_val), 32'h0);
      check_val({tag, "_irq"},  32'(irq),          32'h0);
      check_val({tag, "_oeb"},  32'(io_oeb),       32'hFFFF);
      check_val({tag, "_ack"},  32'(wbs_ack),      32'h0);
      check_val({tag, "_dat"},  wbs_dat_r,         32'h0);
   endtask

   initial begin
      logic [31:0] d;
      logic [15:0] ld, cm, ps;
      logic [31:0] ctrl;
      reset = 0; cnt = 16'h0;
      bus_idle();
      model_reset();

      // Asynchronous reset asserted between clock edges
      #3 reset = 1;
      #1 check_reset_outputs("rst0");
      @(negedge clk) reset = 0;

      wb_read(8'h10, d);
      check_val("status_after_rst", d, 32'h0);

      // Register access and byte lanes
      wb_write(8'h08, 32'hFFFF_0010, 4'b0011);
      wb_write(8'h0C, 32'h0000_0014, 4'b0011);
      wb_write(8'h04, 32'h0000_0000, 4'b0011);
      wb_read(8'h08, d); check_val("load_rb", d, 32'h10);
      wb_read(8'h0C, d); check_val("cmp_rb", d, 32'h14);
      wb_read(8'h04, d); check_val("ps_rb", d, 32'h0);
      wb_write(8'h0C, 32'h0000_ABCD, 4'b0001);
      wb_read(8'h0C, d); check_val("cmp_lowbyte", d, 32'h00CD);
      wb_write(8'h0C, 32'h0000_0014, 4'b0011);

      // Non-hit address never acks; unmapped offset reads zero
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF;
      wbs_adr = BASE + 32'h100; wbs_dat_w = 32'h1;
      idle(3);
      bus_idle();
      wb_read(8'h18, d); check_val("unmapped_rd", d, 32'h0);

      // One-shot run
      n_en = 0;
      wb_write(8'h00, 32'h09, 4'b0001);
      idle(10);
      check_val("oneshot_en_pulses", 32'(n_en), 32'd4);
      wb_read(8'h10, d); check_val("oneshot_status", d, 32'h301);
      wb_read(8'h00, d); check_val("ctrl_rb", d, 32'h08);
      check_val("oneshot_irq", 32'(irq), 32'h1);
      wb_write(8'h10, 32'h1, 4'b0001);
      check_val("irq_cleared", 32'(irq), 32'h0);

      // Periodic with prescaler
      wb_write(8'h04, 32'h2, 4'b0011);
      wb_write(8'h08, 32'h0, 4'b0011);
      wb_write(8'h0C, 32'h3, 4'b0011);
      wb_write(8'h00, 32'h1D, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         idle(3);
         wb_read(8'h10, d);
      end

      // START and STOP together during RUN
      wb_write(8'h00, 32'h1F, 4'b0001);
      idle(2);
      wb_read(8'h10, d); check_val("collision_idle", d & 32'h302, 32'h0);

      // W1C against a match every other cycle: one of the two attempts lands on a match
      wb_write(8'h04, 32'h0, 4'b0011);
      wb_write(8'h08, 32'h5, 4'b0011);
      wb_write(8'h0C, 32'h5, 4'b0011);
      wb_write(8'h00, 32'h0D, 4'b0001);
      idle(3);
      wb_write(8'h10, 32'h1, 4'b0001);
      idle(1);
      wb_write(8'h10, 32'h1, 4'b0001);
      idle(2);
      wb_write(8'h00, 32'h02, 4'b0001);

      // Randomized configurations, restarts, reads and clears
      for (int it = 0; it < 10; it++) begin
         ld = 16'($urandom_range(0, 300));
         cm = ld + 16'($urandom_range(0, 6));
         ps = 16'($urandom_range(0, 3));
         ctrl = {27'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'b01};
         wb_write(8'h04, {16'($urandom), ps}, 4'b0011);
         wb_write(8'h08, {16'($urandom), ld}, 4'b0011);
         wb_write(8'h0C, {16'($urandom), cm}, 4'b0011);
         wb_write(8'h00, ctrl, 4'b0001);
         for (int k = 0; k < int'($urandom_range(4, 10)); k++) begin
            idle(int'($urandom_range(0, 6)));
            case ($urandom_range(0, 3))
               0: wb_read(8'h10, d);
               1: wb_read(8'h14, d);
               2: wb_write(8'h10, 32'h1, 4'b0001);
               default: wb_write(8'h00, ctrl, 4'b0001);
            endcase
         end
         wb_write(8'h00, 32'h02, 4'b0001);
      end

      // Reset in the middle of a run with a read ack pending
      wb_write(8'h00, 32'h1D, 4'b0001);
      idle(4);
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = BASE | 32'h10;
      cycle();
      @(posedge clk);
      #3 reset = 1;
      #1 check_reset_outputs("rst1");
      bus_idle();
      cnt = 16'h0;
      model_reset();
      @(negedge clk) reset = 0;
      wb_read(8'h10, d); check_val("status_after_rst1", d, 32'h0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
